alu_issue_queue: RTL and testbench

//  Command front-end directly upstream of the 8-bit combinational alu (A,B,sel -> out,O).

---
 rtl/alu_issue_queue_pkg.sv | 36 +++
 rtl/alu_issue_queue_cmd_fifo.sv | 59 +++++
 rtl/alu_issue_queue.sv | 128 ++++++++++++
 tb/tb_alu_issue_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared widths, alu opcode names and FSM encoding for the alu issue queue.
// Imported by the queue RTL and by anything that models the alu next to it.
package alu_issue_queue_pkg;

   localparam int unsigned DW  = 8;
   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OpAdd  = 4'h0;
   localparam logic [OPW-1:0] OpSub  = 4'h1;
   localparam logic [OPW-1:0] OpAnd  = 4'h2;
   localparam logic [OPW-1:0] OpOr   = 4'h3;
   localparam logic [OPW-1:0] OpXor  = 4'h4;
   localparam logic [OPW-1:0] OpNotA = 4'h5;
   localparam logic [OPW-1:0] OpShl  = 4'h6;
   localparam logic [OPW-1:0] OpShr  = 4'h7;
   localparam logic [OPW-1:0] OpMul  = 4'h8;
   localparam logic [OPW-1:0] OpPass = 4'h9;
   localparam logic [OPW-1:0] OpInc  = 4'hA;
   localparam logic [OPW-1:0] OpDec  = 4'hB;
   localparam logic [OPW-1:0] OpEq   = 4'hC;
   localparam logic [OPW-1:0] OpLt   = 4'hD;
   localparam logic [OPW-1:0] OpRol  = 4'hE;
   localparam logic [OPW-1:0] OpRor  = 4'hF;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StResp  = 2'd2
   } state_e;

   // Packed command entry: {a, b, sel}.
   function automatic int unsigned cmd_width(input int unsigned dw, input int unsigned opw);
      return 2 * dw + opw;
   endfunction

endpackage

// File: rtl/alu_issue_queue_cmd_fifo.sv
// Command FIFO for the alu issue queue; only pointers and count are reset,
// the storage array is overwritten before it is ever read.
module alu_issue_queue_cmd_fifo #(
   parameter int unsigned W     = 20,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Front-end for the combinational alu: queues {A,B,sel} commands, drives one at a time
// onto registered alu inputs and returns the captured results over a valid/ready response.
module alu_issue_queue
   import alu_issue_queue_pkg::*;
#(
   parameter int unsigned DW    = alu_issue_queue_pkg::DW,
   parameter int unsigned OPW   = alu_issue_queue_pkg::OPW,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH) + 1,
   localparam int unsigned EW   = cmd_width(DW, OPW)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           cmd_valid_i,
   output logic           cmd_ready_o,
   input  logic [DW-1:0]  cmd_a_i,
   input  logic [DW-1:0]  cmd_b_i,
   input  logic [OPW-1:0] cmd_sel_i,
   output logic [DW-1:0]  alu_a_o,
   output logic [DW-1:0]  alu_b_o,
   output logic [OPW-1:0] alu_sel_o,
   input  logic [DW-1:0]  alu_out_i,
   input  logic [DW-1:0]  alu_o_i,
   output logic           rsp_valid_o,
   input  logic           rsp_ready_i,
   output logic [DW-1:0]  rsp_out_o,
   output logic [DW-1:0]  rsp_o_o,
   output logic [OPW-1:0] rsp_sel_o,
   output logic           busy_o,
   output logic [CW-1:0]  count_o
);

   state_e         state_q;
   logic [DW-1:0]  alu_a_q, alu_b_q;
   logic [OPW-1:0] alu_sel_q;
   logic [DW-1:0]  rsp_out_q, rsp_o_q;
   logic [OPW-1:0] rsp_sel_q;
   logic           rsp_valid_q;

   logic           fifo_push, fifo_full, fifo_empty, load;
   logic [EW-1:0]  fifo_head;
   logic [DW-1:0]  head_a, head_b;
   logic [OPW-1:0] head_sel;

   // Held low during reset so nothing is accepted that reset would discard.
   assign cmd_ready_o = !fifo_full && !rst_i;
   assign fifo_push   = cmd_valid_i && cmd_ready_o;
   assign {head_a, head_b, head_sel} = fifo_head;

   alu_issue_queue_cmd_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i ({cmd_a_i, cmd_b_i, cmd_sel_i}),
      .pop_i   (load),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count_o)
   );

   always_comb begin
      load = 1'b0;
      unique case (state_q)
         StIdle:  load = !fifo_empty;
         StResp:  load = rsp_valid_q && rsp_ready_i && !fifo_empty;
         default: load = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_out_q   <= '0;
         rsp_o_q     <= '0;
         rsp_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load) begin
                  alu_a_q   <= head_a;
                  alu_b_q   <= head_b;
                  alu_sel_q <= head_sel;
                  state_q   <= StDrive;
               end
            end
            StDrive: begin
               rsp_out_q   <= alu_out_i;
               rsp_o_q     <= alu_o_i;
               rsp_sel_q   <= alu_sel_q;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (rsp_valid_q && rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  if (load) begin
                     alu_a_q   <= head_a;
                     alu_b_q   <= head_b;
                     alu_sel_q <= head_sel;
                     state_q   <= StDrive;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_sel_o   = alu_sel_q;
   assign rsp_out_o   = rsp_out_q;
   assign rsp_o_o     = rsp_o_q;
   assign rsp_sel_o   = rsp_sel_q;
   assign rsp_valid_o = rsp_valid_q;
   assign busy_o      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural alu wired to the alu_* ports
// and a response scoreboard fed from accepted commands.
module tb_alu_issue_queue;
   import alu_issue_queue_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] cmd_sel = '0;
   logic [7:0] alu_a, alu_b, alu_out, alu_o;
   logic [3:0] alu_sel;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_out, rsp_o;
   logic [3:0] rsp_sel;
   logic       busy;
   logic [2:0] count;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_rsp = 0;
   logic [19:0] exp_q[$];
   logic       rand_en = 1'b0;
   logic       range_en = 1'b0;
   logic       hold = 1'b0;
   logic [19:0] held = '0;

   always #5 clk = ~clk;

   alu_issue_queue u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_a_i     (cmd_a),
      .cmd_b_i     (cmd_b),
      .cmd_sel_i   (cmd_sel),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_sel_o   (alu_sel),
      .alu_out_i   (alu_out),
      .alu_o_i     (alu_o),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_out_o   (rsp_out),
      .rsp_o_o     (rsp_o),
      .rsp_sel_o   (rsp_sel),
      .busy_o      (busy),
      .count_o     (count)
   );

   // Behavioural alu: returns {out, O}.
   function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s);
      logic [8:0]  w;
      logic [15:0] p;
      logic [7:0]  o1, o2;
      w  = '0;
      p  = '0;
      o1 = '0;
      o2 = '0;
      case (s)
         OpAdd:  begin w = {1'b0, a} + {1'b0, b}; o1 = w[7:0]; o2 = {7'd0, w[8]}; end
         OpSub:  begin o1 = a - b; o2 = {7'd0, (a < b)}; end
         OpAnd:  begin o1 = a & b; o2 = a | b; end
         OpOr:   begin o1 = a | b; o2 = a ^ b; end
         OpXor:  begin o1 = a ^ b; o2 = ~a; end
         OpNotA: begin o1 = ~a; o2 = ~b; end
         OpShl:  begin o1 = a << 1; o2 = {7'd0, a[7]}; end
         OpShr:  begin o1 = a >> 1; o2 = {7'd0, a[0]}; end
         OpMul:  begin p = a * b; o1 = p[7:0]; o2 = p[15:8]; end
         OpPass: begin o1 = b; o2 = a; end
         OpInc:  begin o1 = a + 8'd1; o2 = b - 8'd1; end
         OpDec:  begin o1 = a - 8'd1; o2 = b + 8'd1; end
         OpEq:   begin o1 = {7'd0, (a == b)}; o2 = a - b; end
         OpLt:   begin o1 = {7'd0, (a < b)}; o2 = b - a; end
         OpRol:  begin o1 = {a[6:0], a[7]}; o2 = {b[6:0], b[7]}; end
         default: begin o1 = {a[0], a[7:1]}; o2 = {b[0], b[7:1]}; end
      endcase
      return {o1, o2};
   endfunction

   assign {alu_out, alu_o} = alu_model(alu_a, alu_b, alu_sel);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_begin(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = s;
      cmd_valid = 1'b1;
   endtask

   // Completes the handshake started by push_begin; returns at posedge + 1.
   task automatic push_finish();
      logic accepted;
      logic [15:0] r;
      accepted = 1'b0;
      for (int i = 0; i < 500 && !accepted; i++) begin
         @(negedge clk);
         if (cmd_ready) accepted = 1'b1;
      end
      if (!accepted) begin
         check("push_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         r = alu_model(cmd_a, cmd_b, cmd_sel);
         exp_q.push_back({r, cmd_sel});
      end
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      push_begin(a, b, s);
      push_finish();
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(tag, exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Response scoreboard, sampled half a cycle away from the active edge.
   always @(negedge clk) begin
      logic [19:0] cur;
      if (rst) begin
         hold = 1'b0;
      end else begin
         cur = {rsp_out, rsp_o, rsp_sel};
         if (rsp_valid) begin
            if (hold) check("rsp_stable", 32'(cur), 32'(held));
            if (rsp_ready) begin
               n_rsp++;
               if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
               else check("rsp_data", 32'(cur), 32'(exp_q.pop_front()));
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               held = cur;
            end
         end else begin
            hold = 1'b0;
         end
         if (range_en) check("count_range", 32'(count <= 3'd4), 32'd1);
      end
   end

   initial begin
      int base;
      logic [15:0] r;

      // Reset state
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_outputs", {alu_a, alu_b, alu_sel, rsp_valid, busy, count},
            32'd0);
      check("rst_rsp", {rsp_out, rsp_o, rsp_sel}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single op and latency
      rsp_ready = 1'b1;
      push(8'h0A, 8'h02, 4'h1);
      check("e0_count", 32'(count), 32'd1);
      check("e0_no_bypass", 32'(alu_a), 32'h00);
      @(posedge clk);
      #1;
      check("e1_alu_in", {alu_a, alu_b, alu_sel}, {12'd0, 8'h0A, 8'h02, 4'h1});
      check("e1_rsp_valid", 32'(rsp_valid), 32'd0);
      check("e1_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("e2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("e2_rsp", {rsp_out, rsp_o, rsp_sel}, {12'd0, 8'h08, 8'h00, 4'h1});
      drain("single_drain");
      check("single_idle", {busy, count}, 32'd0);

      // Opcode sweep
      base = n_rsp;
      range_en = 1'b1;
      for (int s = 0; s < 16; s++) push(8'h0A, 8'h02, 4'(s));
      drain("sweep_drain");
      check("sweep_rsp_count", 32'(n_rsp - base), 32'd16);

      // Full and backpressure
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(i * 17 + 3), 8'(i + 5), 4'(i + 2));
      push_begin(8'h77, 8'h11, 4'h8);
      repeat (3) @(posedge clk);
      #1;
      check("full_count", 32'(count), 32'd4);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_rsp_valid", 32'(rsp_valid), 32'd1);
      r = alu_model(8'h03, 8'h05, 4'h2);
      check("full_rsp_head", {rsp_out, rsp_o, rsp_sel}, {12'd0, r, 4'h2});
      rsp_ready = 1'b1;
      push_finish();
      drain("bp_drain");
      check("bp_idle", {busy, count}, 32'd0);

      // Pointer wrap with random response backpressure
      base = n_rsp;
      rand_en = 1'b1;
      for (int i = 0; i < 10; i++) push(8'hF6, 8'h0A, 4'(i * 3 + 1));
      rand_en = 1'b0;
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      drain("wrap_drain");
      check("wrap_rsp_count", 32'(n_rsp - base), 32'd10);
      range_en = 1'b0;

      // Reset while driving with three commands queued
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i + 9), 4'(i));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("pre_rst_count", 32'(count), 32'd3);
      check("pre_rst_drive", {rsp_valid, alu_a}, {23'd0, 1'b0, 8'h02});
      rst = 1'b1;
      #1;
      exp_q.delete();
      check("midrst_outputs", {alu_a, alu_b, alu_sel, rsp_valid, busy, count}, 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      base = n_rsp;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check("post_rst_idle", {busy, count}, 32'd0);
      check("post_rst_rsp_count", 32'(n_rsp - base), 32'd0);
      check("post_rst_ready2", 32'(cmd_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
